// File: rtl/wb_master_seq.sv
// wb_master_seq
//   Wishbone classic initiator. A valid/ready command stream (we, sel, addr,
//   wdata) is buffered in a small FIFO, and each command becomes one single
//   Wishbone read or write cycle. Every cycle yields one response on a
//   valid/ready stream: read data for reads, completion status for writes,
//   and an error flag if the slave does not acknowledge in time.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cmd_*                  command stream in (valid/ready handshake)
//   rsp_*                  response stream out (rdata is 0 for writes/errors)
//   wbm_*                  Wishbone classic master interface
//   busy_o                 commands queued or a transaction in flight
//
// Parameters
//   FIFO_DEPTH      command FIFO entries, power of two, >= 2
//   TIMEOUT_CYCLES  bus cycles to wait for ack before error; 0 disables

module wb_master_seq #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  // ---------------------------------------------------------------- FIFO
  // Entry layout: {we, sel[3:0], addr[31:0], wdata[31:0]} = 69 bits.
  logic [68:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [68:0]   head;
  logic          push;
  logic          pop;

  logic [1:0]    state_reg;
  logic [TW-1:0] tmo_reg;
  logic          cyc_reg;
  logic          we_reg;
  logic [3:0]    sel_reg;
  logic [31:0]   adr_reg;
  logic [31:0]   dat_reg;
  logic          rsp_valid_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          rsp_err_reg;
  logic          busy_reg;

  assign cmd_ready_o = (count_reg != CW'(FIFO_DEPTH));
  assign push        = cmd_valid_i & cmd_ready_o;
  assign pop         = (state_reg == ST_IDLE) && (count_reg != '0);
  assign head        = fifo_mem[rd_ptr_reg];

  // Storage is not reset: stale entries are unreachable once count is 0.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_we_i, cmd_sel_i, cmd_addr_i, cmd_wdata_i};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= ST_IDLE;
      tmo_reg       <= '0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            we_reg    <= head[68];
            sel_reg   <= head[67:64];
            adr_reg   <= head[63:32];
            dat_reg   <= head[31:0];
            cyc_reg   <= 1'b1;
            tmo_reg   <= '0;
            state_reg <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (wbm_ack_i) begin
            cyc_reg       <= 1'b0;
            rsp_rdata_reg <= we_reg ? 32'h0 : wbm_dat_i;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RSP;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_reg == TMO_LAST)) begin
            cyc_reg       <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RSP;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        ST_RSP: begin
          // Returning to IDLE here makes the next pop happen one cycle
          // later, leaving an idle bus cycle between transactions.
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cyc_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Registered status; lags the FIFO/FSM by one cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= (count_reg != '0) || (state_reg != ST_IDLE);
    end
  end

  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = cyc_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_sel_o   = sel_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign busy_o      = busy_reg;

endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq
//   Directed bench for wb_master_seq (FIFO_DEPTH=4, TIMEOUT_CYCLES=8).
//   Inputs change and outputs are sampled on the falling clock edge.
//   A small slave process acks a configurable number of cycles after stb.

module tb_wb_master_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  // slave model configuration
  int          ack_delay = 0;      // -1: never ack
  int          wait_cnt  = 0;
  logic        late_ack  = 1'b0;
  logic        data_from_addr = 1'b0;
  logic [31:0] slave_data = 32'h0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_master_seq #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .busy_o      (busy_o)
  );

  // Slave: ack after ack_delay cycles of stb, or whenever late_ack is set.
  always @(negedge wb_clk_i) begin
    logic hit;
    hit = 1'b0;
    if (wbm_cyc_o && wbm_stb_o) begin
      hit = (ack_delay >= 0) && (wait_cnt == ack_delay);
      wait_cnt = wait_cnt + 1;
    end else begin
      wait_cnt = 0;
    end
    wbm_ack_i = hit || late_ack;
    wbm_dat_i = data_from_addr ? (wbm_adr_o ^ 32'h5A5A_0000) : slave_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel);
    int n;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_sel_i   = sel;
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 100) chk("push_wait", 32'd0, 32'd1);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // One command end to end, checking bus fields, cyc length and response.
  task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input int delay, input logic [31:0] sdata,
                        input int exp_cyc, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic do_late);
    int n;
    ack_delay  = delay;
    slave_data = sdata;
    push(we, addr, wdata, sel);
    n = 0;
    while (!wbm_cyc_o && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 20) chk({name, "_cyc_start"}, 32'd0, 32'd1);
    chk({name, "_stb"}, {31'd0, wbm_stb_o}, 32'd1);
    chk({name, "_we"},  {31'd0, wbm_we_o}, {31'd0, we});
    chk({name, "_adr"}, wbm_adr_o, addr);
    chk({name, "_sel"}, {28'd0, wbm_sel_o}, {28'd0, sel});
    if (we) chk({name, "_dat"}, wbm_dat_o, wdata);
    n = 0;
    while (wbm_cyc_o && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk({name, "_cyc_len"}, n, exp_cyc);
    chk({name, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({name, "_rdata"}, rsp_rdata_o, exp_rdata);
    chk({name, "_err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
    if (do_late) begin
      late_ack = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      late_ack = 1'b0;
      chk({name, "_late_valid"}, {31'd0, rsp_valid_o}, 32'd1);
      chk({name, "_late_err"}, {31'd0, rsp_err_o}, 32'd1);
      chk({name, "_late_rdata"}, rsp_rdata_o, 32'd0);
      chk({name, "_late_cyc"}, {31'd0, wbm_cyc_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    chk({name, "_rsp_clear"}, {31'd0, rsp_valid_o}, 32'd0);
    $display("txn %s: cyc=%0d rdata=0x%08h err=%0b", name, exp_cyc, rsp_rdata_o, rsp_err_o);
    repeat (2) @(negedge wb_clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i    = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;
    repeat (3) @(negedge wb_clk_i);

    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err_o}, 32'd0);
    chk("rst_cyc",       {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_stb",       {31'd0, wbm_stb_o}, 32'd0);
    chk("rst_busy",      {31'd0, busy_o}, 32'd0);
    chk("rst_bus",       wbm_adr_o | wbm_dat_o | {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
    $display("txn reset: done");
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // write, ack 2 cycles after stb: cyc high 3 cycles
    do_txn("wr", 1'b1, 32'h3000_0040, 32'hDEAD_BEEF, 4'hF, 2, 32'hFFFF_0000,
           3, 32'h0, 1'b0, 1'b0);
    // zero-wait read
    do_txn("rd0", 1'b0, 32'h3000_0080, 32'h0, 4'hF, 0, 32'h1234_5678,
           1, 32'h1234_5678, 1'b0, 1'b0);
    // no ack: timeout after 8 cycles, late ack ignored
    do_txn("tmo", 1'b0, 32'h3000_00C0, 32'h0, 4'h3, -1, 32'hAAAA_5555,
           8, 32'h0, 1'b1, 1'b1);
    // ack on cycle 8 coincides with timeout: ack wins
    do_txn("ackwin", 1'b0, 32'h3000_0100, 32'h0, 4'hC, 7, 32'hCAFE_F00D,
           8, 32'hCAFE_F00D, 1'b0, 1'b0);

    // FIFO fill with responses stalled
    ack_delay      = 0;
    data_from_addr = 1'b1;
    for (int i = 0; i < 5; i++)
      push(1'b0, 32'h3000_0200 + 32'(4 * i), 32'h0, 4'hF);
    chk("fifo_full_ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("fifo_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_d;
      exp_d = (32'h3000_0200 + 32'(4 * i)) ^ 32'h5A5A_0000;
      chk($sformatf("fifo%0d_valid", i), {31'd0, rsp_valid_o}, 32'd1);
      chk($sformatf("fifo%0d_rdata", i), rsp_rdata_o, exp_d);
      chk($sformatf("fifo%0d_err", i), {31'd0, rsp_err_o}, 32'd0);
      $display("txn fifo%0d: rdata=0x%08h", i, rsp_rdata_o);
      rsp_ready_i = 1'b1;
      @(negedge wb_clk_i);
      rsp_ready_i = 1'b0;
      chk($sformatf("fifo%0d_clear", i), {31'd0, rsp_valid_o}, 32'd0);
      if (i < 4) begin
        chk($sformatf("fifo%0d_idle_gap", i), {31'd0, wbm_cyc_o}, 32'd0);
        @(negedge wb_clk_i);
        chk($sformatf("fifo%0d_next_cyc", i), {31'd0, wbm_cyc_o}, 32'd1);
        @(negedge wb_clk_i);
      end
    end
    chk("fifo_drained_ready", {31'd0, cmd_ready_o}, 32'd1);
    data_from_addr = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // reset during BUS with two commands queued
    ack_delay = -1;
    for (int i = 0; i < 3; i++)
      push(1'b1, 32'h3000_0300 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF);
    chk("mid_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    chk("mid_cyc",       {31'd0, wbm_cyc_o}, 32'd0);
    chk("mid_stb",       {31'd0, wbm_stb_o}, 32'd0);
    chk("mid_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("mid_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("mid_busy",      {31'd0, busy_o}, 32'd0);
    ack_delay = 0;
    repeat (12) @(negedge wb_clk_i);
    chk("mid_flush_cyc",  {31'd0, wbm_cyc_o}, 32'd0);
    chk("mid_flush_rsp",  {31'd0, rsp_valid_o}, 32'd0);
    chk("mid_flush_busy", {31'd0, busy_o}, 32'd0);
    $display("txn midreset: cyc=%0b rsp_valid=%0b busy=%0b", wbm_cyc_o, rsp_valid_o, busy_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Wishbone classic initiator that turns a simple valid/ready command stream into single Wishbone read/write cycles.
- Returns a valid/ready response stream carrying read data and an error flag.
- Commands are buffered in a small FIFO, and each bus cycle is guarded by a timeout.
- Used to drive Wishbone peripheral slaves (e.g. the PWM register banks) from on-chip sequencers and test logic, with no dependency on the management SoC.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 255, bus cycles to wait for ack before error; 0 disables timeout

Ports:
wb_clk_i  input  1  clock; all logic on rising edge
wb_rst_i  input  1  reset, synchronous, active-high
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted when valid&ready
cmd_we_i  input  1  1=write, 0=read
cmd_addr_i  input  32  byte address
cmd_wdata_i  input  32  write data
cmd_sel_i  input  4  byte selects
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  32  read data (0 for writes and errors)
rsp_err_o  output  1  1=timeout
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte selects
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone acknowledge
busy_o  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- One clock (wb_clk_i); reset is synchronous and active-high on wb_rst_i. Reset values:
  - Outputs: cmd_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wbm_cyc_o=0, wbm_stb_o=0, busy_o=0.
  - Bus outputs wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o are all 0.
  - The FIFO is emptied and the FSM is in IDLE.
- Command FIFO:
  - Each entry is 69 bits: we, sel, addr, wdata.
  - cmd_ready_o = !full, combinational from registered count.
  - Push when cmd_valid_i&cmd_ready_o; pop only in IDLE.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - If the FIFO is non-empty, pop the head.
  - Register its fields onto the wbm_* outputs and set cyc=stb=1, then go to BUS.
  - A command accepted at edge E0 reaches IDLE with the FIFO non-empty after E0. It is popped at E1, so cyc/stb are high after E1.
- BUS:
  - Outputs are held stable, and a timeout counter increments each cycle from 0.
  - If wbm_ack_i=1 at the edge:
    - Drop cyc/stb.
    - Latch rsp_rdata_o = we ? 0 : wbm_dat_i and set rsp_err_o=0.
    - Set rsp_valid_o=1 and go to RSP.
  - Else if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1:
    - Drop cyc/stb.
    - Set rsp_rdata_o=0, rsp_err_o=1 and rsp_valid_o=1, then go to RSP.
  - If ack and timeout expiry coincide, ack wins.
  - Zero-wait slaves (ack in the first BUS cycle) give cyc high for exactly 1 cycle.
- RSP:
  - Hold rsp_* until rsp_valid_o&rsp_ready_i, then clear rsp_valid_o and go to IDLE.
  - The next command is popped no earlier than the cycle after the handshake, so there is one idle bus cycle between transactions.
- wbm_ack_i is ignored outside BUS.
- Writes also produce a response, used as completion/err status.
- wbm_* address/data/sel/we hold their last values when cyc=0 (don't-care to slaves).
- Reset mid-transaction:
  - cyc/stb are deasserted at that edge and any pending response is discarded.
  - FIFO contents are lost and no response is generated for flushed commands.
- busy_o is registered and follows FIFO count and FSM state with a 1-cycle lag allowed.

Test Plan:
- Write addr 0x3000_0040, data 0xDEAD_BEEF, sel 0xF; slave acks 2 cycles after stb -> wbm_* match the command and we=1; cyc high 3 cycles; rsp_valid next cycle with err=0, rdata=0.
- Read addr 0x3000_0080; zero-wait slave returns 0x1234_5678 -> cyc high 1 cycle; rsp_rdata_o=0x1234_5678, err=0.
- Read with no ack, TIMEOUT_CYCLES=8 -> cyc high exactly 8 cycles, then rsp_err_o=1, rdata=0; a late ack after cyc drops is ignored.
- Hold rsp_ready_i=0 and push 5 commands with FIFO_DEPTH=4 -> first command popped; cmd_ready_o goes low once 4 entries are queued; after rsp_ready_i=1, all 5 complete in order with one idle cycle between bus cycles.
- Ack and timeout in the same cycle (ack on cycle 8, TIMEOUT_CYCLES=8) -> err=0, read data latched.
- Assert wb_rst_i for 1 cycle during BUS with 2 commands queued -> cyc/stb low after that edge; no rsp_valid; cmd_ready_o=1; busy_o=0.
